// File: rtl/input_event_sampler_pkg.sv
// rtl/input_event_sampler_pkg.sv - event kinds and FIFO entry layout shared by the sampler
package input_event_sampler_pkg;

  localparam logic EVT_KIND_SW  = 1'b0;
  localparam logic EVT_KIND_BTN = 1'b1;

  // FIFO entry is {kind, rise, idx}
  localparam int EVT_IDX_W    = 3;
  localparam int EVT_IDX_LSB  = 0;
  localparam int EVT_RISE_BIT = 3;
  localparam int EVT_KIND_BIT = 4;
  localparam int EVT_W        = 5;

  typedef logic [EVT_W-1:0] evt_t;

  function automatic evt_t pack_evt(input logic kind, input logic rise,
                                    input logic [EVT_IDX_W-1:0] idx);
    evt_t e;
    e = '0;
    e[EVT_KIND_BIT] = kind;
    e[EVT_RISE_BIT] = rise;
    e[EVT_IDX_LSB +: EVT_IDX_W] = idx;
    return e;
  endfunction

endpackage

// File: rtl/input_event_sampler_debounce_cell.sv
// rtl/input_event_sampler_debounce_cell.sv - 2-flop synchroniser, debounce counter and edge pulse for one pad
module debounce_cell #(
  parameter int DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic state,
  output logic edge_pulse,
  output logic edge_level
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Pulse is combinational so the pending bit is set on the same edge stable flips
  assign edge_pulse = (sync2 != stable) && (cnt == CNT_LAST);
  assign edge_level = sync2;
  assign state      = stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_event_sampler.sv
// rtl/input_event_sampler.sv - debounced switch/button levels and prioritised edge event FIFO
module input_event_sampler
  import input_event_sampler_pkg::*;
#(
  parameter int NSW        = 8,
  parameter int NBTN       = 5,
  parameter int DB_CYCLES  = 20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSW-1:0]  sw,
  input  logic [NBTN-1:0] btn,
  output logic [NSW-1:0]  sw_state,
  output logic [NBTN-1:0] btn_state,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_kind,
  output logic            evt_rise,
  output logic [2:0]      evt_idx,
  output logic            evt_overflow,
  input  logic            ovf_clr
);

  localparam int NIN = NSW + NBTN;
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [NIN-1:0] pad_all;
  logic [NIN-1:0] state_all;
  logic [NIN-1:0] edge_all;
  logic [NIN-1:0] lvl_all;

  // Index order doubles as arbitration priority: switches first, then buttons
  assign pad_all = {btn, sw};

  for (genvar g = 0; g < NIN; g++) begin : g_db
    debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .pad        (pad_all[g]),
      .state      (state_all[g]),
      .edge_pulse (edge_all[g]),
      .edge_level (lvl_all[g])
    );
  end

  assign sw_state  = state_all[NSW-1:0];
  assign btn_state = state_all[NIN-1:NSW];

  logic [NIN-1:0] pend;
  logic [NIN-1:0] pdir;
  logic [NIN-1:0] sel_mask;
  logic [NIN-1:0] clr;
  logic [NIN-1:0] accept;
  logic           found;
  logic           push;
  logic           pop;
  logic           full;
  logic           ovf_hit;
  evt_t           push_evt;

  evt_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  evt_t           head;

  always_comb begin
    found    = 1'b0;
    sel_mask = '0;
    push_evt = '0;
    for (int i = 0; i < NIN; i++) begin
      if (pend[i] && !found) begin
        found       = 1'b1;
        sel_mask[i] = 1'b1;
        if (i < NSW) begin
          push_evt = pack_evt(EVT_KIND_SW, pdir[i], EVT_IDX_W'(i));
        end else begin
          push_evt = pack_evt(EVT_KIND_BTN, pdir[i], EVT_IDX_W'(i - NSW));
        end
      end
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = evt_valid && evt_ready;
  assign push    = found && (!full || pop);
  assign clr     = push ? sel_mask : '0;
  // A new edge is accepted unless an older one for the same input is still waiting
  assign accept  = edge_all & ~(pend & ~clr);
  assign ovf_hit = |(edge_all & pend & ~clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      pdir         <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | accept;
      pdir <= (pdir & ~accept) | (lvl_all & accept);
      if (ovf_hit) begin
        evt_overflow <= 1'b1;
      end else if (ovf_clr) begin
        evt_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_kind  = head[EVT_KIND_BIT];
  assign evt_rise  = head[EVT_RISE_BIT];
  assign evt_idx   = head[EVT_IDX_LSB +: EVT_IDX_W];

endmodule

// File: tb/tb_input_event_sampler.sv
// tb/tb_input_event_sampler.sv - scoreboard bench for input_event_sampler with DB_CYCLES=4
module tb_input_event_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_r;
  logic [4:0] btn_r;
  logic [7:0] sw_state;
  logic [4:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_kind;
  logic       evt_rise;
  logic [2:0] evt_idx;
  logic       evt_overflow;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  input_event_sampler #(
    .NSW(8), .NBTN(5), .DB_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw_r),
    .btn          (btn_r),
    .sw_state     (sw_state),
    .btn_state    (btn_state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_kind     (evt_kind),
    .evt_rise     (evt_rise),
    .evt_idx      (evt_idx),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ev(input logic kind, input logic rise, input int idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {kind, rise, i3};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    tick(2);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: each accepted head is compared against the oldest expected event
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_evt: got %0h, expected none", {evt_kind, evt_rise, evt_idx});
      end else begin
        check("evt", {27'd0, evt_kind, evt_rise, evt_idx}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst       = 1'b0;
    sw_r      = '0;
    btn_r     = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick(3);
    check("reset_valid", evt_valid, 0);
    check("reset_ovf", evt_overflow, 0);
    rst = 1'b1;

    // 1: idle after reset
    tick(50);
    check("idle_sw_state", sw_state, 0);
    check("idle_btn_state", btn_state, 0);
    check("idle_valid", evt_valid, 0);
    check("idle_ovf", evt_overflow, 0);

    // 2: sw3 latency and rise/fall events
    sw_r[3] = 1'b1;
    exp_q.push_back(ev(0, 1, 3));
    tick(5);
    check("sw3_before_lat", sw_state[3], 0);
    tick(1);
    check("sw3_at_lat", sw_state[3], 1);
    drain("drain_sw3_rise");
    sw_r[3] = 1'b0;
    exp_q.push_back(ev(0, 0, 3));
    drain("drain_sw3_fall");
    check("sw3_fell", sw_state[3], 0);

    // 3: 3-cycle glitch rejected, 4-cycle hold accepted
    btn_r[1] = 1'b1;
    tick(3);
    btn_r[1] = 1'b0;
    tick(15);
    check("glitch_btn_state", btn_state, 0);
    check("glitch_no_evt", evt_valid, 0);
    btn_r[1] = 1'b1;
    exp_q.push_back(ev(1, 1, 1));
    tick(4);
    drain("drain_btn1");
    check("btn1_state", btn_state[1], 1);

    // 4: simultaneous edges pushed in priority order
    sw_r[0]  = 1'b1;
    sw_r[7]  = 1'b1;
    btn_r[4] = 1'b1;
    exp_q.push_back(ev(0, 1, 0));
    exp_q.push_back(ev(0, 1, 7));
    exp_q.push_back(ev(1, 1, 4));
    drain("drain_multi");

    // 5: six edges against a stalled 4-entry FIFO
    evt_ready = 1'b0;
    sw_r[1]  = 1'b1;
    sw_r[2]  = 1'b1;
    sw_r[5]  = 1'b1;
    btn_r[0] = 1'b1;
    btn_r[1] = 1'b0;
    btn_r[2] = 1'b1;
    exp_q.push_back(ev(0, 1, 1));
    exp_q.push_back(ev(0, 1, 2));
    exp_q.push_back(ev(0, 1, 5));
    exp_q.push_back(ev(1, 1, 0));
    exp_q.push_back(ev(1, 0, 1));
    exp_q.push_back(ev(1, 1, 2));
    tick(20);
    check("stall_valid", evt_valid, 1);
    check("stall_head", {evt_kind, evt_rise, evt_idx}, 5'b01001);
    check("stall_no_ovf", evt_overflow, 0);
    evt_ready = 1'b1;
    drain("drain_six");

    // 6: fill FIFO, then a second sw2 edge while the first is pending
    evt_ready = 1'b0;
    sw_r[4]  = 1'b1;
    sw_r[5]  = 1'b0;
    sw_r[6]  = 1'b1;
    btn_r[3] = 1'b1;
    exp_q.push_back(ev(0, 1, 4));
    exp_q.push_back(ev(0, 0, 5));
    exp_q.push_back(ev(0, 1, 6));
    exp_q.push_back(ev(1, 1, 3));
    tick(15);
    sw_r[2] = 1'b0;
    exp_q.push_back(ev(0, 0, 2));
    tick(8);
    check("ovf_not_yet", evt_overflow, 0);
    sw_r[2] = 1'b1;
    tick(10);
    check("ovf_set", evt_overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", evt_overflow, 0);
    evt_ready = 1'b1;
    drain("drain_ovf");
    check("sw2_final", sw_state[2], 1);

    // Reset mid-stream, then rise events for every input held high
    evt_ready = 1'b0;
    sw_r[3] = 1'b1;
    exp_q.push_back(ev(0, 1, 3));
    tick(12);
    check("pre_reset_valid", evt_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_reset_valid", evt_valid, 0);
    check("mid_reset_sw", sw_state, 0);
    check("mid_reset_btn", btn_state, 0);
    exp_q.delete();
    tick(3);
    for (int i = 0; i < 8; i++) if (sw_r[i]) exp_q.push_back(ev(0, 1, i));
    for (int i = 0; i < 5; i++) if (btn_r[i]) exp_q.push_back(ev(1, 1, i));
    evt_ready = 1'b1;
    rst = 1'b1;
    tick(5);
    check("post_reset_sw_early", sw_state, 0);
    tick(1);
    check("post_reset_sw", sw_state, sw_r);
    check("post_reset_btn", btn_state, btn_r);
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
